// File: rtl/f_rename_pkg.sv
// Shared rename definitions: architectural/physical address widths and the
// renamed-instruction field layout that FDispatch also decodes.
package f_rename_pkg;

    localparam int FPR_AW = 4;
    localparam int PRF_AW = 5;

    typedef struct packed {
        logic [FPR_AW-1:0] fd;
        logic              fd_wen0;
        logic              fd_wen1;
        logic [PRF_AW-1:0] fd_prf0;
        logic [PRF_AW-1:0] fd_prf1;
        logic [PRF_AW-1:0] fs_prf0;
        logic [PRF_AW-1:0] fs_prf1;
        logic [PRF_AW-1:0] ft_prf0;
        logic [PRF_AW-1:0] ft_prf1;
        logic              fs_use0;
        logic              fs_use1;
        logic              ft_use0;
        logic              ft_use1;
    } ren_fields_t;

    localparam int REN_FIELDS_W = $bits(ren_fields_t);

    // A destination half that is not written carries physical register 0.
    function automatic logic [PRF_AW-1:0] gate_prf(input logic wen, input logic [PRF_AW-1:0] prf);
        return wen ? prf : '0;
    endfunction

endpackage

// File: rtl/f_rename_slot.sv
// One payload register with a valid bit; used for the output stage and,
// when enabled, for the skid entry.
module f_rename_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush,
    input  logic         set,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // NOTE: payload is reset as well as valid so every out_* field reads 0 after reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            // NOTE: non-blocking assignments keep all state updates on the same edge.
            valid <= 1'b0;
            q     <= '0;
        end else begin
            if (flush)
                valid <= 1'b0;
            else if (set)
                valid <= 1'b1;
            else if (clr)
                valid <= 1'b0;

            if (set && !flush)
                q <= d;
        end
    end

endmodule

// File: rtl/f_rename.sv
// FP rename stage: allocates fd physical registers, captures fs/ft mappings
// and hands the renamed instruction to FDispatch. Option: F_RENAME_SKID_EN.
module f_rename
    import f_rename_pkg::*;
#(
    parameter int OP_W  = 8,
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [FPR_AW-1:0] in_fd,
    input  logic              in_fd_wen0,
    input  logic              in_fd_wen1,
    input  logic [FPR_AW-1:0] in_fs,
    input  logic [FPR_AW-1:0] in_ft,
    input  logic              in_fs_use0,
    input  logic              in_fs_use1,
    input  logic              in_ft_use0,
    input  logic              in_ft_use1,

    output logic              frename_wen0,
    output logic              frename_wen1,
    output logic [FPR_AW-1:0] frename_waddr,
    input  logic              frename_busy,
    input  logic [PRF_AW-1:0] frename_prf0,
    input  logic [PRF_AW-1:0] frename_prf1,
    output logic [FPR_AW-1:0] frename_fs_addr,
    output logic [FPR_AW-1:0] frename_ft_addr,
    input  logic [PRF_AW-1:0] frename_fs_prf0,
    input  logic [PRF_AW-1:0] frename_fs_prf1,
    input  logic [PRF_AW-1:0] frename_ft_prf0,
    input  logic [PRF_AW-1:0] frename_ft_prf1,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [TAG_W-1:0]  out_tag,
    output logic [FPR_AW-1:0] out_fd,
    output logic              out_fd_wen0,
    output logic              out_fd_wen1,
    output logic [PRF_AW-1:0] out_fd_prf0,
    output logic [PRF_AW-1:0] out_fd_prf1,
    output logic [PRF_AW-1:0] out_fs_prf0,
    output logic [PRF_AW-1:0] out_fs_prf1,
    output logic [PRF_AW-1:0] out_ft_prf0,
    output logic [PRF_AW-1:0] out_ft_prf1,
    output logic              out_fs_use0,
    output logic              out_fs_use1,
    output logic              out_ft_use0,
    output logic              out_ft_use1
);

    localparam int PW = OP_W + TAG_W + REN_FIELDS_W;

    logic          can_take;
    logic          accept;
    logic          out_set;
    logic          out_clr;
    logic [PW-1:0] out_d;
    logic [PW-1:0] out_q;
    logic [PW-1:0] in_pay;
    ren_fields_t   in_f;
    ren_fields_t   out_f;

    // Busy only matters when a destination half actually needs a register.
    assign in_ready = can_take & ~flush & ~(frename_busy & (in_fd_wen0 | in_fd_wen1));
    assign accept   = in_valid & in_ready;

    assign frename_wen0    = in_valid & can_take & ~flush & in_fd_wen0;
    assign frename_wen1    = in_valid & can_take & ~flush & in_fd_wen1;
    assign frename_waddr   = in_fd;
    assign frename_fs_addr = in_fs;
    assign frename_ft_addr = in_ft;

    always_comb begin
        in_f         = '0;
        in_f.fd      = in_fd;
        in_f.fd_wen0 = in_fd_wen0;
        in_f.fd_wen1 = in_fd_wen1;
        in_f.fd_prf0 = gate_prf(in_fd_wen0, frename_prf0);
        in_f.fd_prf1 = gate_prf(in_fd_wen1, frename_prf1);
        in_f.fs_prf0 = frename_fs_prf0;
        in_f.fs_prf1 = frename_fs_prf1;
        in_f.ft_prf0 = frename_ft_prf0;
        in_f.ft_prf1 = frename_ft_prf1;
        in_f.fs_use0 = in_fs_use0;
        in_f.fs_use1 = in_fs_use1;
        in_f.ft_use0 = in_ft_use0;
        in_f.ft_use1 = in_ft_use1;
    end

    assign in_pay = {in_op, in_tag, in_f};

`ifdef F_RENAME_SKID_EN
    logic          skid_valid;
    logic [PW-1:0] skid_q;
    logic          out_open;

    // The output register can take a new entry this cycle.
    assign out_open = ~out_valid | out_ready;
    assign can_take = ~skid_valid;

    // Skid is only ever filled while the output is stalled, so draining it
    // first preserves order; it is empty whenever a new accept happens.
    assign out_set = out_open & (skid_valid | accept);
    assign out_d   = skid_valid ? skid_q : in_pay;
    assign out_clr = out_ready;

    f_rename_slot #(.W(PW)) u_skid (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .set    (accept & ~out_open),
        .clr    (skid_valid & out_open),
        .d      (in_pay),
        .valid  (skid_valid),
        .q      (skid_q)
    );
`else
    assign can_take = ~out_valid | out_ready;
    assign out_set  = accept;
    assign out_d    = in_pay;
    assign out_clr  = out_ready;
`endif

    f_rename_slot #(.W(PW)) u_out (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .set    (out_set),
        .clr    (out_clr),
        .d      (out_d),
        .valid  (out_valid),
        .q      (out_q)
    );

    assign {out_op, out_tag, out_f} = out_q;

    assign out_fd      = out_f.fd;
    assign out_fd_wen0 = out_f.fd_wen0;
    assign out_fd_wen1 = out_f.fd_wen1;
    assign out_fd_prf0 = out_f.fd_prf0;
    assign out_fd_prf1 = out_f.fd_prf1;
    assign out_fs_prf0 = out_f.fs_prf0;
    assign out_fs_prf1 = out_f.fs_prf1;
    assign out_ft_prf0 = out_f.ft_prf0;
    assign out_ft_prf1 = out_f.ft_prf1;
    assign out_fs_use0 = out_f.fs_use0;
    assign out_fs_use1 = out_f.fs_use1;
    assign out_ft_use0 = out_f.ft_use0;
    assign out_ft_use1 = out_f.ft_use1;

endmodule

// File: tb/tb_f_rename.sv
// Self-checking bench for f_rename (default build, no skid): directed test-plan
// steps followed by random traffic against a one-entry output model.
module tb_f_rename;

    logic       clk = 1'b0;
    logic       resetn, flush;
    logic       in_valid, in_ready;
    logic [7:0] in_op;
    logic [4:0] in_tag;
    logic [3:0] in_fd, in_fs, in_ft;
    logic       in_fd_wen0, in_fd_wen1;
    logic       in_fs_use0, in_fs_use1, in_ft_use0, in_ft_use1;
    logic       frename_wen0, frename_wen1;
    logic [3:0] frename_waddr, frename_fs_addr, frename_ft_addr;
    logic       frename_busy;
    logic [4:0] frename_prf0, frename_prf1;
    logic [4:0] frename_fs_prf0, frename_fs_prf1, frename_ft_prf0, frename_ft_prf1;
    logic       out_valid, out_ready;
    logic [7:0] out_op;
    logic [4:0] out_tag;
    logic [3:0] out_fd;
    logic       out_fd_wen0, out_fd_wen1;
    logic [4:0] out_fd_prf0, out_fd_prf1, out_fs_prf0, out_fs_prf1, out_ft_prf0, out_ft_prf1;
    logic       out_fs_use0, out_fs_use1, out_ft_use0, out_ft_use1;

    f_rename #(.OP_W(8), .TAG_W(5)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_tag(in_tag),
        .in_fd(in_fd), .in_fd_wen0(in_fd_wen0), .in_fd_wen1(in_fd_wen1),
        .in_fs(in_fs), .in_ft(in_ft),
        .in_fs_use0(in_fs_use0), .in_fs_use1(in_fs_use1),
        .in_ft_use0(in_ft_use0), .in_ft_use1(in_ft_use1),
        .frename_wen0(frename_wen0), .frename_wen1(frename_wen1),
        .frename_waddr(frename_waddr), .frename_busy(frename_busy),
        .frename_prf0(frename_prf0), .frename_prf1(frename_prf1),
        .frename_fs_addr(frename_fs_addr), .frename_ft_addr(frename_ft_addr),
        .frename_fs_prf0(frename_fs_prf0), .frename_fs_prf1(frename_fs_prf1),
        .frename_ft_prf0(frename_ft_prf0), .frename_ft_prf1(frename_ft_prf1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_tag(out_tag), .out_fd(out_fd),
        .out_fd_wen0(out_fd_wen0), .out_fd_wen1(out_fd_wen1),
        .out_fd_prf0(out_fd_prf0), .out_fd_prf1(out_fd_prf1),
        .out_fs_prf0(out_fs_prf0), .out_fs_prf1(out_fs_prf1),
        .out_ft_prf0(out_ft_prf0), .out_ft_prf1(out_ft_prf1),
        .out_fs_use0(out_fs_use0), .out_fs_use1(out_fs_use1),
        .out_ft_use0(out_ft_use0), .out_ft_use1(out_ft_use1)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         resetn, flush, in_valid, busy, out_ready;
        logic [7:0] op;
        logic [4:0] tag;
        logic [3:0] fd, fs, ft;
        bit         wen0, wen1, fsu0, fsu1, ftu0, ftu1;
        logic [4:0] prf0, prf1, fsp0, fsp1, ftp0, ftp1;
    } stim_t;

    int errors = 0;
    int checks = 0;

    // Reference state: what FDispatch should currently be offered.
    bit          exp_valid;
    logic [52:0] exp_held;
    bit          exp_known;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{resetn: 1'b1, out_ready: 1'b1, default: '0};
        return s;
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        s.resetn    = ($urandom_range(0, 99) != 0);
        s.flush     = ($urandom_range(0, 15) == 0);
        s.in_valid  = ($urandom_range(0, 3) != 0);
        s.busy      = ($urandom_range(0, 3) == 0);
        s.out_ready = ($urandom_range(0, 9) < 7);
        s.op  = 8'($urandom);  s.tag = 5'($urandom);
        s.fd  = 4'($urandom);  s.fs  = 4'($urandom);  s.ft = 4'($urandom);
        s.wen0 = 1'($urandom); s.wen1 = 1'($urandom);
        s.fsu0 = 1'($urandom); s.fsu1 = 1'($urandom);
        s.ftu0 = 1'($urandom); s.ftu1 = 1'($urandom);
        s.prf0 = 5'($urandom); s.prf1 = 5'($urandom);
        s.fsp0 = 5'($urandom); s.fsp1 = 5'($urandom);
        s.ftp0 = 5'($urandom); s.ftp1 = 5'($urandom);
        return s;
    endfunction

    // Renamed instruction as FDispatch must see it; unwritten fd halves carry 0.
    function automatic logic [52:0] renamed(input stim_t s);
        return {s.op, s.tag, s.fd, s.wen0, s.wen1,
                s.wen0 ? s.prf0 : 5'd0, s.wen1 ? s.prf1 : 5'd0,
                s.fsp0, s.fsp1, s.ftp0, s.ftp1, s.fsu0, s.fsu1, s.ftu0, s.ftu1};
    endfunction

    function automatic logic [52:0] dut_out();
        return {out_op, out_tag, out_fd, out_fd_wen0, out_fd_wen1,
                out_fd_prf0, out_fd_prf1, out_fs_prf0, out_fs_prf1,
                out_ft_prf0, out_ft_prf1, out_fs_use0, out_fs_use1, out_ft_use0, out_ft_use1};
    endfunction

    // Drive one cycle from the falling edge, check, then advance the model at the rising edge.
    task automatic step(input stim_t s);
        bit room, rdy, acc;
        resetn = s.resetn;   flush = s.flush;   in_valid = s.in_valid;
        frename_busy = s.busy; out_ready = s.out_ready;
        in_op = s.op; in_tag = s.tag; in_fd = s.fd; in_fs = s.fs; in_ft = s.ft;
        in_fd_wen0 = s.wen0; in_fd_wen1 = s.wen1;
        in_fs_use0 = s.fsu0; in_fs_use1 = s.fsu1; in_ft_use0 = s.ftu0; in_ft_use1 = s.ftu1;
        frename_prf0 = s.prf0; frename_prf1 = s.prf1;
        frename_fs_prf0 = s.fsp0; frename_fs_prf1 = s.fsp1;
        frename_ft_prf0 = s.ftp0; frename_ft_prf1 = s.ftp1;
        #1;
        room = !exp_valid || s.out_ready;
        rdy  = room && !s.flush && !(s.busy && (s.wen0 || s.wen1));
        acc  = s.in_valid && rdy;
        check("in_ready", 64'(in_ready), 64'(rdy));
        check("wen0", 64'(frename_wen0), 64'(s.in_valid && room && !s.flush && s.wen0));
        check("wen1", 64'(frename_wen1), 64'(s.in_valid && room && !s.flush && s.wen1));
        check("addrs", 64'({frename_waddr, frename_fs_addr, frename_ft_addr}), 64'({s.fd, s.fs, s.ft}));
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        if (exp_valid || exp_known)
            check("payload", 64'(dut_out()), 64'(exp_held));
        @(posedge clk);
        if (!s.resetn) begin
            exp_valid = 0; exp_held = '0; exp_known = 1;
        end else if (s.flush) begin
            exp_valid = 0;
        end else if (acc) begin
            exp_valid = 1; exp_held = renamed(s); exp_known = 1;
        end else if (s.out_ready) begin
            exp_valid = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        stim_t s;
        s = idle_stim();
        s.resetn = 0;
        resetn = 0; flush = 0; in_valid = 0; frename_busy = 0; out_ready = 1;
        repeat (2) @(negedge clk);
        exp_valid = 0; exp_held = '0; exp_known = 1;

        // Reset state, then a dual-half allocation.
        step(idle_stim());
        s = idle_stim();
        s.in_valid = 1; s.fd = 3; s.wen0 = 1; s.wen1 = 1; s.prf0 = 17; s.prf1 = 20;
        s.fs = 3; s.fsp0 = 3; s.fsp1 = 3; s.fsu0 = 1; s.op = 8'h5a; s.tag = 5'd9;
        step(s);
        #0;
        check("tp1_prf0", 64'(out_fd_prf0), 64'd17);
        check("tp1_prf1", 64'(out_fd_prf1), 64'd20);
        check("tp1_fs_prf0", 64'(out_fs_prf0), 64'd3);
        step(idle_stim());

        // Busy for three cycles with the request held, then release.
        s.fd = 5; s.prf0 = 7; s.prf1 = 8; s.tag = 5'd10; s.busy = 1;
        repeat (3) step(s);
        s.busy = 0;
        step(s);
        step(idle_stim());

        // Output stalled while three instructions queue up behind it.
        for (int i = 0; i < 3; i++) begin
            s = rnd_stim();
            s.resetn = 1; s.flush = 0; s.busy = 0; s.in_valid = 1; s.wen0 = 1;
            s.out_ready = (i != 0) ? 1'b1 : 1'b0;
            if (i == 0) begin
                s.out_ready = 1;
                step(s);
                s.out_ready = 0;
                repeat (4) step(s);
            end else begin
                step(s);
            end
        end
        step(idle_stim());

        // Flush against a valid output and a pending input.
        s = idle_stim(); s.in_valid = 1; s.wen0 = 1; s.prf0 = 11; s.out_ready = 0;
        step(s);
        s.flush = 1;
        step(s);
        step(idle_stim());

        // fd-less instruction ignores busy.
        s = idle_stim(); s.in_valid = 1; s.busy = 1; s.prf0 = 30; s.prf1 = 31; s.op = 8'hc3;
        step(s);
        check("tp5_prf", 64'({out_fd_prf0, out_fd_prf1}), 64'd0);
        check("tp5_valid", 64'(out_valid), 64'd1);

        // Reset mid-stream with a valid output.
        s = idle_stim(); s.in_valid = 1; s.wen1 = 1; s.prf1 = 19; s.out_ready = 0;
        step(s);
        s.resetn = 0;
        step(s);
        check("tp6_valid", 64'(out_valid), 64'd0);
        check("tp6_fields", 64'(dut_out()), 64'd0);

        for (int i = 0; i < 400; i++)
            step(rnd_stim());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
